// File: rtl/ex_mem_reg_if.sv
// EX/MEM stage bundle: EX-side inputs, registered MEM-side outputs,
// hazard-unit controls and the data-memory acknowledge.
interface ex_mem_reg_if;
  // hazard / flow control
  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  // EX-stage payload
  logic [31:0] ALUResult_i;
  logic        Zero_i;
  logic [31:0] RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        Branch_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  // data memory acknowledge
  logic        mem_ready_i;
  // registered MEM-stage view
  logic [31:0] ALUResult_o;
  logic [31:0] RS2data_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        valid_o;
  logic        busy_o;
  logic        branch_taken_o;
  logic [31:0] branch_target_o;
  logic [15:0] stall_cycles_o;

  // Pipeline register side
  modport slave (
    input  stall_i, flush_i, valid_i, ALUResult_i, Zero_i, RS2data_i, RDaddr_i,
           RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i, pc_i, imm_i,
           mem_ready_i,
    output ALUResult_o, RS2data_o, RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o,
           MemWrite_o, valid_o, busy_o, branch_taken_o, branch_target_o,
           stall_cycles_o
  );

  // Upstream / environment side
  modport master (
    output stall_i, flush_i, valid_i, ALUResult_i, Zero_i, RS2data_i, RDaddr_i,
           RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i, pc_i, imm_i,
           mem_ready_i,
    input  ALUResult_o, RS2data_o, RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o,
           MemWrite_o, valid_o, busy_o, branch_taken_o, branch_target_o,
           stall_cycles_o
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for an RV32 core.
// Captures the ALU result and MEM/WB controls, resolves BEQ from the
// captured Zero flag, holds while a data-memory access is unacknowledged
// and counts (saturating) the cycles spent waiting on memory.
module ex_mem_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  ex_mem_reg_if.slave bus
);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t      state_reg, state_next;

  logic        valid_reg, valid_next;
  logic [31:0] alu_reg, alu_next;
  logic [31:0] rs2_reg, rs2_next;
  logic [4:0]  rd_reg, rd_next;
  logic        reg_write_reg, reg_write_next;
  logic        mem_to_reg_reg, mem_to_reg_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic        taken_reg, taken_next;
  logic [31:0] target_reg, target_next;
  logic [15:0] stall_cnt_reg, stall_cnt_next;

  logic        busy;
  logic        do_flush;
  logic        do_load;
  logic        mem_op_in;
  logic        taken_in;
  logic [31:0] target_sum;
  logic        unused_imm_msb;

  // An entry waiting on memory freezes the whole register, flush included,
  // so the in-flight access is never dropped.
  assign busy      = (state_reg == MEMWAIT) && !bus.mem_ready_i;
  assign do_flush  = !busy && bus.flush_i;
  assign do_load   = !busy && !bus.flush_i && !bus.stall_i;
  assign mem_op_in = bus.valid_i && (bus.MemRead_i || bus.MemWrite_i);
  assign taken_in  = bus.valid_i && bus.Branch_i && bus.Zero_i;

  // Immediate is in halfwords; bit 31 falls off the shift and the add wraps.
  assign target_sum     = bus.pc_i + {bus.imm_i[30:0], 1'b0};
  assign unused_imm_msb = bus.imm_i[31];

  // Next-state and next-contents selection, defaults hold everything
  always_comb begin
    state_next      = state_reg;
    valid_next      = valid_reg;
    alu_next        = alu_reg;
    rs2_next        = rs2_reg;
    rd_next         = rd_reg;
    reg_write_next  = reg_write_reg;
    mem_to_reg_next = mem_to_reg_reg;
    mem_read_next   = mem_read_reg;
    mem_write_next  = mem_write_reg;
    target_next     = target_reg;
    taken_next      = 1'b0;

    // Acknowledge arriving while waiting releases the entry.
    if ((state_reg == MEMWAIT) && bus.mem_ready_i) begin
      state_next = RUN;
    end

    if (do_flush) begin
      // Bubble: kill validity and controls, leave the datapath as it was.
      state_next      = RUN;
      valid_next      = 1'b0;
      reg_write_next  = 1'b0;
      mem_to_reg_next = 1'b0;
      mem_read_next   = 1'b0;
      mem_write_next  = 1'b0;
    end else if (do_load) begin
      valid_next      = bus.valid_i;
      alu_next        = bus.ALUResult_i;
      rs2_next        = bus.RS2data_i;
      rd_next         = bus.RDaddr_i;
      reg_write_next  = bus.RegWrite_i & bus.valid_i;
      mem_to_reg_next = bus.MemtoReg_i & bus.valid_i;
      mem_read_next   = bus.MemRead_i & bus.valid_i;
      mem_write_next  = bus.MemWrite_i & bus.valid_i;
      target_next     = target_sum;
      taken_next      = taken_in;
      // A memory op acknowledged on its own load edge needs no wait state.
      state_next      = (mem_op_in && !bus.mem_ready_i) ? MEMWAIT : RUN;
    end

    stall_cnt_next = stall_cnt_reg;
    if (busy && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  // State and entry registers with asynchronous active-low clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= RUN;
      valid_reg      <= 1'b0;
      alu_reg        <= 32'd0;
      rs2_reg        <= 32'd0;
      rd_reg         <= 5'd0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      taken_reg      <= 1'b0;
      target_reg     <= 32'd0;
      stall_cnt_reg  <= 16'd0;
    end else begin
      state_reg      <= state_next;
      valid_reg      <= valid_next;
      alu_reg        <= alu_next;
      rs2_reg        <= rs2_next;
      rd_reg         <= rd_next;
      reg_write_reg  <= reg_write_next;
      mem_to_reg_reg <= mem_to_reg_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      taken_reg      <= taken_next;
      target_reg     <= target_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  assign bus.ALUResult_o     = alu_reg;
  assign bus.RS2data_o       = rs2_reg;
  assign bus.RDaddr_o        = rd_reg;
  assign bus.RegWrite_o      = reg_write_reg;
  assign bus.MemtoReg_o      = mem_to_reg_reg;
  assign bus.MemRead_o       = mem_read_reg;
  assign bus.MemWrite_o      = mem_write_reg;
  assign bus.valid_o         = valid_reg;
  assign bus.busy_o          = busy;
  assign bus.branch_taken_o  = taken_reg;
  assign bus.branch_target_o = target_reg;
  assign bus.stall_cycles_o  = stall_cnt_reg;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: expected images are pushed to a scoreboard
// when stimulus is applied and popped/compared half a cycle after the edge.
module tb_ex_mem_reg;

  logic clk;
  logic rst_n;

  ex_mem_reg_if bus ();

  ex_mem_reg dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
    logic        mr;
    logic        mw;
    logic        busy;
    logic        taken;
    logic [31:0] target;
    logic [15:0] cnt;
    bit          chk_data;
    bit          chk_target;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  task automatic check_pop();
    exp_t x;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    x = sb.pop_front();
    cmp(x.tag, "valid", {31'd0, bus.valid_o}, {31'd0, x.valid});
    cmp(x.tag, "RegWrite", {31'd0, bus.RegWrite_o}, {31'd0, x.rw});
    cmp(x.tag, "MemtoReg", {31'd0, bus.MemtoReg_o}, {31'd0, x.mtr});
    cmp(x.tag, "MemRead", {31'd0, bus.MemRead_o}, {31'd0, x.mr});
    cmp(x.tag, "MemWrite", {31'd0, bus.MemWrite_o}, {31'd0, x.mw});
    cmp(x.tag, "busy", {31'd0, bus.busy_o}, {31'd0, x.busy});
    cmp(x.tag, "taken", {31'd0, bus.branch_taken_o}, {31'd0, x.taken});
    cmp(x.tag, "stall_cycles", {16'd0, bus.stall_cycles_o}, {16'd0, x.cnt});
    if (x.chk_data) begin
      cmp(x.tag, "ALUResult", bus.ALUResult_o, x.alu);
      cmp(x.tag, "RS2data", bus.RS2data_o, x.rs2);
      cmp(x.tag, "RDaddr", {27'd0, bus.RDaddr_o}, {27'd0, x.rd});
    end
    if (x.chk_target) cmp(x.tag, "target", bus.branch_target_o, x.target);
  endtask

  task automatic push(input string tag);
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One clock edge, then compare at the following falling edge.
  task automatic step(input string tag);
    push(tag);
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mtr,
                       input logic mr, input logic mw);
    bus.valid_i     = v;
    bus.ALUResult_i = alu;
    bus.RS2data_i   = rs2;
    bus.RDaddr_i    = rd;
    bus.RegWrite_i  = rw;
    bus.MemtoReg_i  = mtr;
    bus.MemRead_i   = mr;
    bus.MemWrite_i  = mw;
  endtask

  // Expected image after reset
  task automatic exp_zero();
    e.valid = 0; e.alu = 0; e.rs2 = 0; e.rd = 0;
    e.rw = 0; e.mtr = 0; e.mr = 0; e.mw = 0;
    e.busy = 0; e.taken = 0; e.target = 0; e.cnt = 0;
    e.chk_data = 1; e.chk_target = 1;
  endtask

  task automatic exp_entry(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic rw, input logic mtr,
                           input logic mr, input logic mw);
    e.valid = v; e.alu = alu; e.rs2 = rs2; e.rd = rd;
    e.rw = rw; e.mtr = mtr; e.mr = mr; e.mw = mw;
    e.chk_data = 1; e.chk_target = 0; e.taken = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall_i = 0; bus.flush_i = 0; bus.Zero_i = 0; bus.Branch_i = 0;
    bus.pc_i = 0; bus.imm_i = 0; bus.mem_ready_i = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_zero();
    repeat (2) @(negedge clk);
    push("reset"); check_pop();
    rst_n = 1'b1;

    // Reset mid-operation
    drive(1, 32'h0000_0010, 0, 5'd5, 1, 0, 0, 0);
    exp_entry(1, 32'h0000_0010, 0, 5'd5, 1, 0, 0, 0); e.busy = 0;
    step("add_load");
    #2 rst_n = 1'b0;
    #1 exp_zero(); push("async_rst"); check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load right after release
    drive(1, 32'h1234_5678, 0, 5'd7, 1, 0, 0, 0);
    exp_entry(1, 32'h1234_5678, 0, 5'd7, 1, 0, 0, 0); e.busy = 0; e.cnt = 0;
    step("basic_load");

    // Memory wait: load with no ack, hold three wait edges, then ack
    bus.mem_ready_i = 0;
    drive(1, 32'h0000_0200, 32'h0BAD_F00D, 5'd9, 1, 1, 1, 0);
    exp_entry(1, 32'h0000_0200, 32'h0BAD_F00D, 5'd9, 1, 1, 1, 0); e.busy = 1; e.cnt = 0;
    step("mw_load");
    drive(1, 32'hDEAD_BEEF, 0, 5'd3, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      e.cnt = 16'(i);
      step("mw_hold");
    end
    bus.mem_ready_i = 1;
    exp_entry(1, 32'hDEAD_BEEF, 0, 5'd3, 1, 0, 0, 0); e.busy = 0; e.cnt = 3;
    step("mw_release");
    bus.mem_ready_i = 0;
    step("run_after_mw");
    bus.mem_ready_i = 1;

    // Branch resolution
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    bus.Branch_i = 1; bus.Zero_i = 1; bus.pc_i = 32'h0000_0100; bus.imm_i = 32'hFFFF_FFF8;
    exp_entry(1, 0, 0, 0, 0, 0, 0, 0);
    e.taken = 1; e.target = 32'h0000_00F0; e.chk_target = 1;
    step("beq_taken");
    bus.stall_i = 1;
    e.taken = 0; e.chk_target = 0;
    step("beq_pulse_end");
    bus.stall_i = 0; bus.Zero_i = 0;
    step("beq_not_taken");
    bus.Zero_i = 1; bus.pc_i = 32'hFFFF_FFF0; bus.imm_i = 32'h0000_0010;
    e.taken = 1; e.target = 32'h0000_0010; e.chk_target = 1;
    step("beq_wrap");
    bus.pc_i = 32'h0000_0100; bus.imm_i = 32'h8000_0004;
    e.taken = 1; e.target = 32'h0000_0108; e.chk_target = 1;
    step("beq_imm31");
    bus.valid_i = 0;
    e.valid = 0; e.taken = 0; e.chk_target = 0;
    step("beq_bubble");
    bus.Branch_i = 0; bus.Zero_i = 0; bus.pc_i = 0; bus.imm_i = 0;

    // Flush together with stall on a MemWrite
    drive(1, 32'h0000_0077, 0, 5'd4, 1, 0, 0, 0);
    exp_entry(1, 32'h0000_0077, 0, 5'd4, 1, 0, 0, 0);
    step("pre_flush");
    drive(1, 32'h0000_0300, 32'h0000_0005, 5'd6, 0, 0, 0, 1);
    bus.mem_ready_i = 0; bus.flush_i = 1; bus.stall_i = 1;
    exp_entry(0, 32'h0000_0077, 0, 5'd4, 0, 0, 0, 0); e.busy = 0;
    step("flush_stall");
    bus.flush_i = 0;
    step("stall_hold_bubble");
    bus.stall_i = 0; bus.mem_ready_i = 1;
    drive(1, 32'h0000_0088, 0, 5'd2, 1, 0, 0, 0);
    exp_entry(1, 32'h0000_0088, 0, 5'd2, 1, 0, 0, 0);
    step("load_plain2");
    bus.stall_i = 1; bus.mem_ready_i = 0;
    drive(1, 32'h0000_0099, 0, 5'd1, 0, 0, 0, 0);
    step("stall_nonmem");
    bus.stall_i = 0;

    // Flush while waiting on memory is ignored until the ack
    drive(1, 32'h0000_0400, 32'h0000_0ABC, 5'd0, 0, 0, 0, 1);
    exp_entry(1, 32'h0000_0400, 32'h0000_0ABC, 5'd0, 0, 0, 0, 1); e.busy = 1; e.cnt = 3;
    step("sw_load");
    bus.flush_i = 1;
    e.cnt = 4;
    step("flush_in_busy");
    bus.mem_ready_i = 1;
    exp_entry(0, 32'h0000_0400, 32'h0000_0ABC, 5'd0, 0, 0, 0, 0); e.busy = 0; e.cnt = 4;
    step("flush_after_ready");
    bus.flush_i = 0;

    // Bubble load never writes and never waits
    bus.mem_ready_i = 0;
    drive(0, 32'h0000_0111, 0, 5'd13, 1, 1, 1, 0);
    exp_entry(0, 0, 0, 0, 0, 0, 0, 0); e.chk_data = 0; e.busy = 0;
    step("bubble_load");
    step("bubble_no_wait");

    // Memory op acknowledged on its own load edge
    bus.mem_ready_i = 1;
    drive(1, 32'h0000_0500, 0, 5'd8, 1, 1, 1, 0);
    exp_entry(1, 32'h0000_0500, 0, 5'd8, 1, 1, 1, 0); e.busy = 0;
    step("lw_ready");
    bus.stall_i = 1; bus.mem_ready_i = 0;
    step("lw_ready_hold");
    bus.stall_i = 0;

    // Reset abandons a pending access
    drive(1, 32'h0000_0600, 0, 5'd10, 1, 1, 1, 0);
    exp_entry(1, 32'h0000_0600, 0, 5'd10, 1, 1, 1, 0); e.busy = 1; e.cnt = 4;
    step("lw_wait2");
    #2 rst_n = 1'b0;
    #1 exp_zero(); push("rst_memwait"); check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h0000_0700, 0, 5'd11, 1, 0, 0, 0);
    exp_entry(1, 32'h0000_0700, 0, 5'd11, 1, 0, 0, 0); e.busy = 0; e.cnt = 0;
    step("post_rst_load");

    // Stall-cycle counter saturation
    drive(1, 32'h0000_0800, 0, 5'd12, 1, 1, 1, 0);
    exp_entry(1, 32'h0000_0800, 0, 5'd12, 1, 1, 1, 0); e.busy = 1; e.cnt = 0;
    step("sat_load");
    repeat (65532) @(posedge clk);
    @(negedge clk);
    e.cnt = 16'hFFFC;
    for (int i = 0; i < 8; i++) begin
      if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
      step("sat_count");
    end
    bus.mem_ready_i = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_entry(0, 0, 0, 0, 0, 0, 0, 0); e.chk_data = 0; e.busy = 0; e.cnt = 16'hFFFF;
    step("sat_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register directly downstream of the ALU. It captures the ALU result, the Zero flag, store data, the destination register and the MEM/WB control bits on each clock edge. It resolves BEQ branches from the captured Zero flag and holds its contents while a data-memory access is not yet acknowledged. It also counts memory-wait cycles for performance monitoring.

## Interface
- No parameters; all widths are fixed for RV32.
- clk_i  in  1  pipeline clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  downstream/hazard hold request; register keeps its contents.
- flush_i  in  1  insert a bubble at the next edge.
- valid_i  in  1  the EX-stage instruction is real (not a bubble).
- ALUResult_i  in  32  ALU data_o.
- Zero_i  in  1  ALU Zero_o (operands equal).
- RS2data_i  in  32  forwarded rs2 value, used as store data.
- RDaddr_i  in  5  destination register.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i  in  1 each  control bits from ID/EX.
- pc_i  in  32  PC of the EX instruction.
- imm_i  in  32  sign-extended branch immediate, in halfword units.
- mem_ready_i  in  1  data memory acknowledges the current access.
- ALUResult_o, RS2data_o  out  32  registered copies.
- RDaddr_o  out  5  registered destination.
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  registered control; forced 0 when the entry is invalid.
- valid_o  out  1  the entry holds a real instruction.
- busy_o  out  1  memory access pending; the hazard unit must stall IF/ID/EX.
- branch_taken_o  out  1  one-cycle pulse: the captured BEQ is taken.
- branch_target_o  out  32  pc + (imm << 1); meaningful only while branch_taken_o = 1.
- stall_cycles_o  out  16  saturating count of busy cycles.

## Operation
- State machine with two states:
  - RUN: the entry is free to advance.
  - MEMWAIT: the entry holds a MemRead or MemWrite awaiting mem_ready_i.
- Transitions:
  - RUN→MEMWAIT at an edge that loads a valid memory op while mem_ready_i = 0 at that edge.
  - An op loaded while mem_ready_i = 1 completes in one cycle and stays in RUN.
  - MEMWAIT→RUN on the first edge where mem_ready_i = 1.
- busy_o = (state == MEMWAIT) & !mem_ready_i. It is combinational from the state and mem_ready_i.
- Update priority per edge:
  1. reset
  2. busy_o: hold everything
  3. flush_i: load a bubble (valid_o = 0, all control outputs 0, data/RDaddr don't-care but held)
  4. stall_i: hold
  5. otherwise: load all inputs
- Loading with valid_i = 0 is equivalent to loading a bubble.
- The control outputs RegWrite_o/MemtoReg_o/MemRead_o/MemWrite_o are stored ANDed with the loaded valid bit, so a bubble can never write.
- Branch resolution on a load with valid_i & Branch_i & Zero_i:
  - branch_taken_o = 1 for exactly one cycle.
  - branch_target_o = pc_i + {imm_i[30:0], 1'b0}, a 32-bit add that wraps modulo 2^32 with no overflow flag.
- branch_taken_o clears on the following edge even if the entry is then held by busy_o or stall_i.
- Flush of the younger instructions after a taken branch is done by the hazard unit, not by this block.
- stall_cycles_o increments on every edge where busy_o = 1. It saturates at 16'hFFFF and never wraps.

## Timing
- Latency: one cycle from inputs to the registered outputs.
- busy_o and branch_taken_o are visible in the cycle after the capturing edge.
- Reset (rst_i = 0), asynchronous and immediate:
  - valid_o, all control outputs, busy_o, branch_taken_o = 0.
  - ALUResult_o, RS2data_o, branch_target_o = 0; RDaddr_o = 0; stall_cycles_o = 0; state = RUN.
- Reset asserted mid-MEMWAIT abandons the access. After release the block is in RUN with an empty entry.
- mem_ready_i high on the same edge that loads a memory op: the op completes, there is no MEMWAIT, and busy_o is never asserted.
- flush_i and stall_i together: flush wins and a bubble is loaded.
- flush_i during busy_o is ignored, because the in-flight memory op must complete. The hazard unit re-issues the flush if it is still needed.
- A non-memory entry held by stall_i keeps busy_o = 0 and does not count stall cycles.

## Test plan
- Reset mid-operation: load a valid ADD (ALUResult_i = 32'h0000_0010, RDaddr_i = 5, RegWrite_i = 1), then pull rst_i low between edges → all outputs 0 immediately; after release the first edge captures new inputs normally.
- Basic load: valid ADD with result 32'h1234_5678, rd = 7 → next cycle ALUResult_o = 32'h1234_5678, RDaddr_o = 7, RegWrite_o = 1, valid_o = 1, busy_o = 0.
- Memory wait: load a MemRead with mem_ready_i = 0 for 3 cycles, then 1 → busy_o high for 3 cycles; outputs held despite changing inputs; stall_cycles_o = 3; state returns to RUN.
- Branch: Branch_i = 1, Zero_i = 1, pc_i = 32'h0000_0100, imm_i = 32'hFFFF_FFF8 → branch_taken_o pulses for 1 cycle with branch_target_o = 32'h0000_00F0. The same stimulus with Zero_i = 0 → no pulse.
- Flush vs stall vs busy:
  - flush_i = 1 with stall_i = 1 on a valid MemWrite input → valid_o = 0 and MemWrite_o = 0.
  - flush_i during MEMWAIT → ignored until mem_ready_i = 1.
- Saturation: hold MEMWAIT for 65,540 cycles → stall_cycles_o stops at 16'hFFFF.
